// File: rtl/hunter_fan_pkg.sv
// Shared definitions for the Hunter fan remote link, used by both the transmitter
// and the receiver (packet_decoder).
package hunter_fan_pkg;

  // Default link timing and identity
  localparam int unsigned CHIP_CYCLES_DEF   = 2203;
  localparam int unsigned TOL_DEF           = 550;
  localparam logic [3:0]  DEV_ID_DEF        = 4'b1010;
  localparam int unsigned GLITCH_CYCLES_DEF = 16;

  // Packet layout, LSB first: preamble, id, payload
  localparam int unsigned PRE_BITS     = 2;
  localparam int unsigned ID_BITS      = 4;
  localparam int unsigned PAYLOAD_BITS = 7;
  localparam int unsigned PKT_BITS     = 13;
  localparam int unsigned ID_LSB       = PRE_BITS;
  localparam int unsigned PAYLOAD_LSB  = PRE_BITS + ID_BITS;

  // Duration counter width
  localparam int unsigned CNT_W = 13;

  // Payload codes, written payload[6:0]
  localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_CMD0 = 7'b1001111;
  localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_CMD1 = 7'b1000111;
  localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_CMD2 = 7'b0100111;
  localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_CMD3 = 7'b0010111;
  localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_CMD4 = 7'b0001111;

  typedef enum logic [1:0] {
    ErrTiming     = 2'd0,
    ErrIdMismatch = 2'd1,
    ErrPayload    = 2'd2,
    ErrTimeout    = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StDone
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] cmd;
  } cmd_lookup_t;

  function automatic cmd_lookup_t payload_to_cmd(input logic [PAYLOAD_BITS-1:0] payload);
    cmd_lookup_t res;
    res.hit = 1'b1;
    res.cmd = 3'd0;
    case (payload)
      PAYLOAD_CMD0: res.cmd = 3'd0;
      PAYLOAD_CMD1: res.cmd = 3'd1;
      PAYLOAD_CMD2: res.cmd = 3'd2;
      PAYLOAD_CMD3: res.cmd = 3'd3;
      PAYLOAD_CMD4: res.cmd = 3'd4;
      default:      res.hit = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rf_line_conditioner.sv
// RF line front end: 2-flop synchroniser, optional glitch filter (GLITCH_FILTER_EN),
// then an edge register producing one-cycle rise/fall pulses.
module rf_line_conditioner
  import hunter_fan_pkg::*;
`ifdef GLITCH_FILTER_EN
#(
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF
)
`endif
(
  input  logic ref_clk,
  input  logic reset,
  input  logic i_rf,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync1, r_sync2;
  logic r_prev, r_rise, r_fall;
  logic w_level;

  // Bring the asynchronous line into the ref_clk domain
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_rf;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GLITCH_FILTER_EN
  localparam int unsigned GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

  logic [GW-1:0] r_stable_cnt;
  logic          r_filt;

  // Adopt a new level only after GLITCH_CYCLES consecutive differing samples
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_filt       <= 1'b0;
      r_stable_cnt <= '0;
    end else if (r_sync2 == r_filt) begin
      r_stable_cnt <= '0;
    end else if (r_stable_cnt == GW'(GLITCH_CYCLES - 1)) begin
      r_filt       <= r_sync2;
      r_stable_cnt <= '0;
    end else begin
      r_stable_cnt <= r_stable_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  // Registered edge detection on the conditioned level
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/packet_decoder.sv
// Hunter fan remote receiver: measures PWM chip durations, decodes the 13-bit packet,
// checks the device ID and maps the payload to a fan command.
// Build option: GLITCH_FILTER_EN inserts a glitch filter in the line conditioner.
module packet_decoder
  import hunter_fan_pkg::*;
#(
  parameter int unsigned CHIP_CYCLES   = CHIP_CYCLES_DEF,
  parameter int unsigned TOL           = TOL_DEF,
`ifdef GLITCH_FILTER_EN
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF,
`endif
  parameter logic [3:0]  DEV_ID        = DEV_ID_DEF
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       rf_in,
  output logic       valid,
  output logic [2:0] cmd,
  output logic [3:0] rx_id,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam logic [CNT_W-1:0] W1_LO = CNT_W'(CHIP_CYCLES - TOL);
  localparam logic [CNT_W-1:0] W1_HI = CNT_W'(CHIP_CYCLES + TOL);
  localparam logic [CNT_W-1:0] W2_LO = CNT_W'(2 * CHIP_CYCLES - TOL);
  localparam logic [CNT_W-1:0] W2_HI = CNT_W'(2 * CHIP_CYCLES + TOL);

  logic                  w_rise, w_fall;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_in_w1, w_in_w2, w_timeout;

  rx_state_e             r_state, w_state_d;
  logic [3:0]            r_bit_cnt, w_bit_cnt_d;
  logic                  r_cur_bit, w_cur_bit_d;
  logic [PKT_BITS-1:0]   r_shift, w_shift_d;

  logic                  w_valid_set, w_err_set;
  err_code_e             w_err_code_new;
  logic [2:0]            w_cmd_new;
  logic [ID_BITS-1:0]    w_id;
  cmd_lookup_t           w_lookup;

  logic                  r_valid, r_err;
  logic [2:0]            r_cmd;
  logic [3:0]            r_rx_id;
  err_code_e             r_err_code;

`ifdef GLITCH_FILTER_EN
  rf_line_conditioner #(
    .GLITCH_CYCLES (GLITCH_CYCLES)
  ) u_line (
`else
  rf_line_conditioner u_line (
`endif
    .ref_clk (ref_clk),
    .reset   (reset),
    .i_rf    (rf_in),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Duration since the last edge; restarts at 1 on an edge, saturates at all-ones
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_rise || w_fall) begin
      r_cnt <= CNT_W'(1);
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_in_w1   = (r_cnt >= W1_LO) && (r_cnt <= W1_HI);
  assign w_in_w2   = (r_cnt >= W2_LO) && (r_cnt <= W2_HI);
  assign w_timeout = (r_cnt > W2_HI);

  assign w_id     = r_shift[ID_LSB +: ID_BITS];
  assign w_lookup = payload_to_cmd(r_shift[PAYLOAD_LSB +: PAYLOAD_BITS]);

  // FSM state, bit counter and shift register
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_cur_bit <= 1'b0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_cur_bit <= w_cur_bit_d;
      r_shift   <= w_shift_d;
    end
  end

  // Next-state decode; r_bit_cnt is the index of the bit currently being received
  always_comb begin
    w_state_d      = r_state;
    w_bit_cnt_d    = r_bit_cnt;
    w_cur_bit_d    = r_cur_bit;
    w_shift_d      = r_shift;
    w_valid_set    = 1'b0;
    w_err_set      = 1'b0;
    w_err_code_new = ErrTiming;
    w_cmd_new      = r_cmd;
    unique case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_d   = StHigh;
          w_bit_cnt_d = '0;
          w_cur_bit_d = 1'b0;
        end
      end
      StHigh: begin
        if (w_timeout) begin
          w_err_set      = 1'b1;
          w_err_code_new = ErrTimeout;
          w_state_d      = StIdle;
        end else if (w_fall) begin
          if (r_cur_bit ? w_in_w2 : w_in_w1) begin
            w_shift_d = {r_cur_bit, r_shift[PKT_BITS-1:1]};
            if (r_bit_cnt == 4'(PKT_BITS - 1)) begin
              w_state_d = StDone;
            end else begin
              w_state_d   = StLow;
              w_bit_cnt_d = r_bit_cnt + 4'd1;
            end
          end else begin
            w_err_set = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      StLow: begin
        if (w_timeout) begin
          w_err_set      = 1'b1;
          w_err_code_new = ErrTimeout;
          w_state_d      = StIdle;
        end else if (w_rise) begin
          // Short low means 1, long low means 0; preamble bits must be 0
          if (w_in_w1 && (r_bit_cnt >= 4'(PRE_BITS))) begin
            w_cur_bit_d = 1'b1;
            w_state_d   = StHigh;
          end else if (w_in_w2) begin
            w_cur_bit_d = 1'b0;
            w_state_d   = StHigh;
          end else begin
            w_err_set = 1'b1;
            w_state_d = StIdle;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
        if (w_id != DEV_ID) begin
          w_err_set      = 1'b1;
          w_err_code_new = ErrIdMismatch;
        end else if (!w_lookup.hit) begin
          w_err_set      = 1'b1;
          w_err_code_new = ErrPayload;
        end else begin
          w_valid_set = 1'b1;
          w_cmd_new   = w_lookup.cmd;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Registered result pulses and held result fields
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_cmd      <= '0;
      r_rx_id    <= '0;
      r_err_code <= ErrTiming;
    end else begin
      r_valid <= w_valid_set;
      r_err   <= w_err_set;
      if (w_valid_set) begin
        r_cmd   <= w_cmd_new;
        r_rx_id <= w_id;
      end
      if (w_err_set) begin
        r_err_code <= w_err_code_new;
        r_rx_id    <= w_id;
      end
    end
  end

  assign valid    = r_valid;
  assign err      = r_err;
  assign cmd      = r_cmd;
  assign rx_id    = r_rx_id;
  assign err_code = r_err_code;
  assign busy     = (r_state != StIdle);

endmodule
